// File: rtl/div_seq_pkg.sv
// Shared constants for the sequential divider: op codes, FSM encoding, latency.
// SIGNED_DIV_EN selects signed DIV/REM support (adds the FIX state).
package div_seq_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Cycles beyond WIDTH from accept to o_valid on the iterative path.
`ifdef SIGNED_DIV_EN
    localparam int LAT_EXTRA = 2;
`else
    localparam int LAT_EXTRA = 1;
`endif

endpackage

// File: rtl/div_seq_cla.sv
// Carry-lookahead adder/subtractor; sum = a + (b ^ {sub_en}) + sub_en.
module div_seq_cla #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub_en,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W-1:0] bx;
    logic [W-1:0] g;
    logic [W-1:0] p;

    assign bx = b ^ {W{sub_en}};
    assign g  = a & bx;
    assign p  = a ^ bx;

    always_comb begin
        logic c;
        c    = sub_en;
        sum  = '0;
        for (int i = 0; i < W; i++) begin
            sum[i] = p[i] ^ c;
            c      = g[i] | (p[i] & c);
        end
        cout = c;
    end

endmodule

// File: rtl/div_seq.sv
// Sequential restoring divider/remainder unit sharing one WIDTH+1 CLA.
// Build option: SIGNED_DIV_EN enables signed DIV/REM (RISC-V M semantics).
//
// state | meaning
// IDLE  | ready, accepts a request; adder negates i_a for signed magnitude
// CALC  | one restoring step per cycle, counter WIDTH-1 down to 0
// FIX   | sign correction of the selected result through the adder
// DONE  | register o_result, pulse o_valid, return to IDLE
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_flush,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_result
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             rdy_q;
    logic             op_rem;
    logic             neg_q;
    logic             neg_r;
    logic             neg_b;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;

    logic [WIDTH:0]   cla_a;
    logic [WIDTH:0]   cla_b;
    logic             cla_sub;
    logic [WIDTH:0]   cla_sum;
    logic             cla_cout;

    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic             div_zero;
    logic             ovf;
    logic             unused_sum_msb;

`ifdef SIGNED_DIV_EN
    assign signed_op = ~i_op[0];
`else
    logic unused_op;
    assign signed_op = 1'b0;
    assign unused_op = i_op[0];
`endif

    assign a_neg    = signed_op & i_a[WIDTH-1];
    assign b_neg    = signed_op & i_b[WIDTH-1];
    assign a_mag    = a_neg ? cla_sum[WIDTH-1:0] : i_a;
    assign div_zero = (i_b == '0);
    assign ovf      = signed_op && (i_a == {1'b1, {(WIDTH-1){1'b0}}}) && (i_b == '1);
    assign o_ready  = rdy_q && (state == ST_IDLE);
    assign unused_sum_msb = cla_sum[WIDTH];

    // A negative divisor is added in its raw two's-complement form, so its
    // magnitude never has to be formed; carry-out still means "fits".
    always_comb begin
        cla_a   = '0;
        cla_b   = '0;
        cla_sub = 1'b1;
        case (state)
            ST_IDLE: cla_b = {1'b0, i_a};
            ST_CALC: begin
                cla_a   = {rem, quo[WIDTH-1]};
                cla_b   = {neg_b, dvs};
                cla_sub = ~neg_b;
            end
            ST_FIX:  cla_b = {1'b0, op_rem ? rem : quo};
            default: ;
        endcase
    end

    div_seq_cla #(.W(WIDTH + 1)) u_cla (
        .a      (cla_a),
        .b      (cla_b),
        .sub_en (cla_sub),
        .sum    (cla_sum),
        .cout   (cla_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            rdy_q    <= 1'b0;
            op_rem   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            neg_b    <= 1'b0;
            dvs      <= '0;
            quo      <= '0;
            rem      <= '0;
            o_valid  <= 1'b0;
            o_result <= '0;
        end else begin
            rdy_q   <= 1'b1;
            o_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_valid && rdy_q) begin
                        op_rem <= i_op[1];
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        neg_b  <= b_neg;
                        dvs    <= i_b;
                        cnt    <= CNT_W'(WIDTH - 1);
                        if (div_zero) begin
                            quo   <= '1;
                            rem   <= i_a;
                            state <= ST_DONE;
                        end else if (ovf) begin
                            quo   <= i_a;
                            rem   <= '0;
                            state <= ST_DONE;
                        end else begin
                            quo   <= a_mag;
                            rem   <= '0;
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (i_flush) begin
                        state <= ST_IDLE;
                    end else begin
                        quo <= {quo[WIDTH-2:0], cla_cout};
                        rem <= cla_cout ? cla_sum[WIDTH-1:0] : {rem[WIDTH-2:0], quo[WIDTH-1]};
                        if (cnt == '0) begin
                            state <= (LAT_EXTRA == 2) ? ST_FIX : ST_DONE;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end
                ST_FIX: begin
                    if (i_flush) begin
                        state <= ST_IDLE;
                    end else begin
                        if (op_rem && neg_r) rem <= cla_sum[WIDTH-1:0];
                        if (!op_rem && neg_q) quo <= cla_sum[WIDTH-1:0];
                        state <= ST_DONE;
                    end
                end
                default: begin
                    o_valid  <= 1'b1;
                    o_result <= op_rem ? rem : quo;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: driver pushes model results, monitor pops on o_valid.
// Expected values follow SIGNED_DIV_EN the same way the build does.
module tb_div_seq;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_valid;
    logic          o_ready;
    logic [1:0]    i_op;
    logic [W-1:0]  i_a;
    logic [W-1:0]  i_b;
    logic          i_flush;
    logic          o_valid;
    logic [W-1:0]  o_result;

    typedef struct {
        logic [W-1:0] res;
        int           lat;
        int           acc;
    } exp_t;

    exp_t         exp_q[$];
    int           cyc = 0;
    int           n_vec = 0;
    int           n_err = 0;
    logic [W-1:0] last_res = '0;

    div_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_op     (i_op),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_flush  (i_flush),
        .o_valid  (o_valid),
        .o_result (o_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic with the architectural corner cases.
    function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output int lat);
        bit     sgn;
        int     normal;
        longint sa;
        longint sb;
`ifdef SIGNED_DIV_EN
        sgn    = !op[0];
        normal = W + 2;
`else
        sgn    = 1'b0;
        normal = W + 1;
`endif
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 0) begin
            r   = op[1] ? a : {W{1'b1}};
            lat = 1;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r   = op[1] ? '0 : a;
            lat = 1;
        end else if (sgn) begin
            r   = op[1] ? W'(sa % sb) : W'(sa / sb);
            lat = normal;
        end else begin
            r   = op[1] ? (a % b) : (a / b);
            lat = normal;
        end
    endfunction

    task automatic push(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int acc);
        logic [W-1:0] r;
        int           lat;
        model(op, a, b, r, lat);
        exp_q.push_back('{res: r, lat: lat, acc: acc});
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int t = 0;
        while (!o_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!o_ready) begin
            check("send_timeout", 64'(o_ready), 64'd1);
        end else begin
            i_valid = 1'b1;
            i_op    = op;
            i_a     = a;
            i_b     = b;
            push(op, a, b, cyc + 1);
            @(negedge clk);
            i_valid = 1'b0;
            i_op    = 2'($urandom);
            i_a     = $urandom;
            i_b     = $urandom;
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [W-1:0] rnd_b();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return '0;
        if (sel == 1) return '1;
        if (sel < 5) return $urandom >> $urandom_range(0, 31);
        return $urandom;
    endfunction

    always @(negedge clk) begin
        if (rst_n && o_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 64'(o_valid), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", 64'(o_result), 64'(e.res));
                check("latency", 64'(cyc - e.acc), 64'(e.lat));
                last_res = e.res;
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_op    = '0;
        i_a     = '0;
        i_b     = '0;
        i_flush = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(o_ready), 64'd0);
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_result", 64'(o_result), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 64'(o_ready), 64'd1);

        // Directed cases, issued back to back.
        send(2'b01, 32'd100, 32'd7);
        send(2'b11, 32'd100, 32'd7);
        send(2'b00, 32'hFFFF_FFF9, 32'd2);
        send(2'b10, 32'hFFFF_FFF9, 32'd2);
        send(2'b00, 32'd7, 32'hFFFF_FFFE);
        send(2'b10, 32'd7, 32'hFFFF_FFFE);
        send(2'b01, 32'd5, 32'd0);
        send(2'b11, 32'd5, 32'd0);
        send(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        send(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        drain();

        // Randomized requests.
        for (int i = 0; i < 120; i++) begin
            logic [W-1:0] a;
            a = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
            send(2'($urandom), a, rnd_b());
        end
        drain();

        // Flush mid-CALC: no result, o_result holds, then a fresh request.
        send(2'b01, $urandom | 32'h1, 32'd13);
        repeat (5) @(negedge clk);
        i_flush = 1'b1;
        exp_q.delete(exp_q.size() - 1);
        @(negedge clk);
        i_flush = 1'b0;
        check("flush_ready", 64'(o_ready), 64'd1);
        check("flush_hold", 64'(o_result), 64'(last_res));
        repeat (40) @(negedge clk);
        check("flush_hold_late", 64'(o_result), 64'(last_res));
        send(2'b01, 32'd9, 32'd3);
        drain();

        // Flush alongside an accept, and flush during DONE: both complete.
        i_flush = 1'b1;
        send(2'b01, 32'd1000, 32'd10);
        i_flush = 1'b0;
        drain();
        send(2'b11, 32'd77, 32'd0);
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        drain();

        // Reset mid-CALC.
        send(2'b01, $urandom | 32'h1, 32'd7);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete(exp_q.size() - 1);
        @(negedge clk);
        check("midrst_valid", 64'(o_valid), 64'd0);
        check("midrst_result", 64'(o_result), 64'd0);
        check("midrst_ready", 64'(o_ready), 64'd0);
        rst_n = 1'b1;
        last_res = '0;
        @(negedge clk);
        check("midrst_ready_rel", 64'(o_ready), 64'd1);
        check("midrst_result_rel", 64'(o_result), 64'd0);
        repeat (40) @(negedge clk);

        // i_valid held high with operands changing every cycle.
        for (int i = 0; i < 300; i++) begin
            logic [1:0]   op;
            logic [W-1:0] a;
            logic [W-1:0] b;
            op = 2'($urandom);
            a  = $urandom;
            b  = ($urandom_range(0, 1) == 0) ? '0 : rnd_b();
            i_valid = 1'b1;
            i_op    = op;
            i_a     = a;
            i_b     = b;
            if (o_ready) push(op, a, b, cyc + 1);
            @(negedge clk);
        end
        i_valid = 1'b0;
        drain();

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port i_valid  input  1  request strobe.
REQ-005 SHALL have port o_ready  output  1  high only in IDLE; a request is accepted on an edge where i_valid && o_ready.
REQ-006 SHALL have port i_op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 SHALL have port i_a  input  WIDTH  dividend.
REQ-008 SHALL have port i_b  input  WIDTH  divisor.
REQ-009 SHALL have port i_flush  input  1  abort of the in-flight operation.
REQ-010 SHALL have port o_valid  output  1  one-cycle result strobe.
REQ-011 SHALL have port o_result  output  WIDTH  quotient or remainder.

Function
REQ-012 SHALL implement a registered FSM with states IDLE, CALC, FIX and DONE.
REQ-013 On accept, SHALL latch i_op/i_a/i_b (operands converted to magnitudes for signed ops); the inputs are don't-care afterwards.
REQ-014 Accept SHALL transition IDLE->DONE for a special case, otherwise IDLE->CALC.
REQ-015 Special case: i_b==0 SHALL yield quotient all-ones and remainder i_a.
REQ-016 Special case: signed i_a==most-negative with i_b==all-ones SHALL yield quotient i_a and remainder 0.
REQ-017 CALC SHALL last exactly WIDTH cycles, counting WIDTH-1 down to 0, running restoring division one bit per cycle.
REQ-018 Each CALC step SHALL shift the partial remainder, trial-subtract the divisor on a WIDTH+1-bit adder, and keep the difference when carry-out=1 (quotient bit 1), else restore it (quotient bit 0).
REQ-019 CALC SHALL transition to FIX after count 0.
REQ-020 FIX SHALL negate the quotient when signed operand signs differ, and negate the remainder when the signed dividend is negative, using the same adder; FIX SHALL then go to DONE.
REQ-021 DONE SHALL register o_result, assert o_valid for exactly one cycle, then return to IDLE.
REQ-022 Normal latency: o_valid SHALL be high WIDTH+2 cycles after the accepting edge.
REQ-023 Special-case latency: o_valid SHALL be high 1 cycle after the accepting edge.
REQ-024 o_result SHALL hold its value until the next DONE.
REQ-025 i_valid while o_ready=0 SHALL be ignored, with no queuing.
REQ-026 A back-to-back request SHALL be acceptable on the cycle after DONE.
REQ-027 i_flush in CALC or FIX SHALL force IDLE next edge, with no o_valid and o_result unchanged.
REQ-028 i_flush in IDLE or DONE SHALL have no effect; DONE still completes.
REQ-029 i_flush together with an accept SHALL give the accept priority.

Reset
REQ-030 rst_n=0 at an edge SHALL force IDLE, o_valid=0, o_result=0, counter=0 and all operand registers=0, including mid-CALC/FIX.
REQ-031 While rst_n=0, o_ready SHALL be 0; on the first edge with rst_n=1 it SHALL be 1.

Configuration
REQ-032 With SIGNED_DIV_EN defined, DIV/REM SHALL follow RISC-V M signed semantics: quotient truncates toward zero and the remainder takes the dividend's sign.
REQ-033 Without SIGNED_DIV_EN, i_op[0] SHALL be ignored (all ops unsigned), FIX SHALL be bypassed (CALC->DONE, latency WIDTH+1) and the overflow special case SHALL not exist.

Structure
REQ-034 A shared package SHALL hold the op encodings (OP_DIV..OP_REMU), the FSM state encoding and the SIGNED_DIV_EN-dependent latency constant.
REQ-035 SHALL instantiate exactly one existing CLA sub-module at WIDTH+1 bits, shared between CALC trial-subtract and FIX negation (a=0, subEn=1); no other adder SHALL be used.

Verification
REQ-036 Bench SHALL check: DIVU 100/7 -> 14, and REMU 100/7 -> 2; o_valid exactly 34 cycles after accept (WIDTH=32, signed build).
REQ-037 Bench SHALL check: DIV -7/2 -> -3 (0xFFFFFFFD), and REM -7/2 -> -1; DIV 7/-2 -> -3, and REM 7/-2 -> 1.
REQ-038 Bench SHALL check: DIVU 5/0 -> 0xFFFFFFFF, and REMU 5/0 -> 5, with o_valid 1 cycle after accept; signed DIV 0x80000000/0xFFFFFFFF -> 0x80000000, and REM -> 0.
REQ-039 Bench SHALL check: reset asserted at CALC cycle 10 -> o_valid never asserted, o_result=0, o_ready=1 on the first cycle after release.
REQ-040 Bench SHALL check: i_flush at CALC cycle 5 -> IDLE next cycle, no o_valid, o_result keeps the prior value; a new DIVU 9/3 accepted afterwards returns 3.
REQ-041 Bench SHALL check: i_valid held high continuously with changing operands -> only the IDLE-cycle operands are accepted, one o_valid per accept, no dropped or duplicated results.
